// File: rtl/mux2_rr_arbiter_if.sv
// Operand/handshake bundle between two requesters, the round-robin arbiter
// and the ALU input stage.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_src;

  // Requester / consumer side.
  modport master (
    output req0, req1, data0, data1,
    input  gnt0, gnt1, sel, busy, out_valid, out_data, out_src
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, data0, data1,
    output gnt0, gnt1, sel, busy, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for a shared 2:1 operand mux: grants one requester,
// captures its operand, holds the path for OP_CYCLES, then strobes out_valid.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int OP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mux2_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(OP_CYCLES - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic             last_grant;
  logic             winner;
  logic [WIDTH-1:0] win_data;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    winner   = bus.req1;
    if (bus.req0 && bus.req1) winner = ~last_grant;
    win_data = winner ? bus.data1 : bus.data0;
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      last_grant    <= 1'b1;
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.sel       <= 1'b0;
      bus.busy      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= 1'b0;
    end else begin
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            bus.gnt0     <= ~winner;
            bus.gnt1     <= winner;
            bus.sel      <= winner;
            bus.out_src  <= winner;
            bus.out_data <= win_data;
            last_grant   <= winner;
            cnt          <= CNT_LOAD;
            bus.busy     <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // Requests are deliberately ignored while the operation runs.
          if (cnt == 4'd0) begin
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed self-checking bench for mux2_rr_arbiter with OP_CYCLES=2.
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int OP    = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mux2_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux2_rr_arbiter #(
    .WIDTH     (WIDTH),
    .OP_CYCLES (OP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".gnt0"},      bus.gnt0,      0);
    check({tag, ".gnt1"},      bus.gnt1,      0);
    check({tag, ".sel"},       bus.sel,       0);
    check({tag, ".busy"},      bus.busy,      0);
    check({tag, ".out_valid"}, bus.out_valid, 0);
    check({tag, ".out_data"},  bus.out_data,  0);
    check({tag, ".out_src"},   bus.out_src,   0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    check_cleared("reset");
    rst_n = 1'b1;
  endtask

  // Called in the cycle right after a grant edge; walks BUSY and DONE back to IDLE.
  task automatic run_op(input string tag, input logic src, input logic [7:0] data);
    check({tag, ".gnt0"},      bus.gnt0,      !src);
    check({tag, ".gnt1"},      bus.gnt1,      src);
    check({tag, ".sel"},       bus.sel,       src);
    check({tag, ".out_src"},   bus.out_src,   src);
    check({tag, ".out_data"},  bus.out_data,  data);
    check({tag, ".busy"},      bus.busy,      1);
    check({tag, ".out_valid"}, bus.out_valid, 0);
    for (int i = 0; i < OP - 1; i++) begin
      step();
      check({tag, ".busy_gnt0"}, bus.gnt0,      0);
      check({tag, ".busy_gnt1"}, bus.gnt1,      0);
      check({tag, ".busy_ov"},   bus.out_valid, 0);
      check({tag, ".busy_busy"}, bus.busy,      1);
      check({tag, ".busy_data"}, bus.out_data,  data);
    end
    step();
    check({tag, ".done_ov"},   bus.out_valid, 1);
    check({tag, ".done_busy"}, bus.busy,      1);
    check({tag, ".done_gnt"},  {bus.gnt1, bus.gnt0}, 0);
    check({tag, ".done_data"}, bus.out_data,  data);
    step();
    check({tag, ".idle_ov"},   bus.out_valid, 0);
    check({tag, ".idle_busy"}, bus.busy,      0);
    check({tag, ".idle_sel"},  bus.sel,       src);
    check({tag, ".idle_data"}, bus.out_data,  data);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    #2;
    check_cleared("async_reset");
    apply_reset();

    // Lone req0: single service, requester drops on grant.
    bus.req0  = 1'b1;
    bus.data0 = 8'hA5;
    step();
    bus.req0  = 1'b0;
    run_op("t1", 1'b0, 8'hA5);
    step();
    check("t1.no_regrant", {bus.gnt1, bus.gnt0}, 0);

    // First tie after reset, then continuous dual requests alternate 0,1,...
    apply_reset();
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.data0 = 8'h11;
    bus.data1 = 8'h22;
    for (int g = 0; g < 6; g++) begin
      step();
      run_op($sformatf("t3.g%0d", g), 1'(g % 2), (g % 2) ? 8'h22 : 8'h11);
    end

    // Lone req1 held high: back-to-back grants, out_data follows data1.
    bus.req0  = 1'b0;
    bus.req1  = 1'b1;
    for (int g = 0; g < 3; g++) begin
      bus.data1 = 8'(g);
      step();
      run_op($sformatf("t4.g%0d", g), 1'b1, 8'(g));
    end

    // req0 drops and data0 changes during BUSY: captured operand holds.
    bus.req1  = 1'b0;
    bus.req0  = 1'b1;
    bus.data0 = 8'h3C;
    step();
    bus.req0  = 1'b0;
    bus.data0 = 8'hFF;
    run_op("t5", 1'b0, 8'h3C);

    // Reset in the middle of BUSY after granting req1.
    bus.req1  = 1'b1;
    bus.data1 = 8'h5A;
    step();
    check("t6.gnt1", bus.gnt1, 1);
    check("t6.data", bus.out_data, 8'h5A);
    bus.req1  = 1'b0;
    step();
    check("t6.mid_busy", bus.busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("t6.async");
    step();
    check("t6.no_ov0", bus.out_valid, 0);
    step();
    check("t6.no_ov1", bus.out_valid, 0);
    rst_n     = 1'b1;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.data0 = 8'h77;
    bus.data1 = 8'h88;
    step();
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    run_op("t6.tie", 1'b0, 8'h77);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
